// File: rtl/sha256_pkg.sv
// SHA-256 constants, helper functions and shared types for the xunitF compression unit.
package sha256_pkg;

   typedef logic [31:0] word_t;

   // Working variables a..h, with a in the most significant word.
   typedef struct packed {
      word_t a;
      word_t b;
      word_t c;
      word_t d;
      word_t e;
      word_t f;
      word_t g;
      word_t h;
   } work_t;

   localparam int         WORDS_PER_RUN = 16;
   localparam logic [3:0] LAST_WORD     = 4'(WORDS_PER_RUN - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      DELAY  = ST_DELAY,
      STREAM = ST_STREAM,
      FINISH = ST_FINISH
   } state_t;

   localparam word_t IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam word_t K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t big_sigma0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t big_sigma1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t ch(input word_t e, input word_t f, input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t maj(input word_t a, input word_t b, input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   // Working-variable set loaded with the initial hash value.
   function automatic work_t iv_work();
      return {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};
   endfunction

   // Select working variable i (0 = a .. 7 = h).
   function automatic word_t work_get(input work_t w, input int unsigned i);
      case (i)
         0:       return w.a;
         1:       return w.b;
         2:       return w.c;
         3:       return w.d;
         4:       return w.e;
         5:       return w.f;
         6:       return w.g;
         default: return w.h;
      endcase
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: next a..h from current a..h, W and K.
module sha256_round
   import sha256_pkg::*;
(
   input  work_t cur,
   input  word_t w,
   input  word_t k,
   output work_t nxt
);

   word_t t1;
   word_t t2;

   // Round function; all sums wrap modulo 2^32.
   always_comb begin
      t1    = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
      t2    = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
      nxt   = '0;
      nxt.a = t1 + t2;
      nxt.b = cur.a;
      nxt.c = cur.b;
      nxt.d = cur.c;
      nxt.e = cur.d + t1;
      nxt.f = cur.e;
      nxt.g = cur.f;
      nxt.h = cur.g;
   end

endmodule

// File: rtl/xunitf.sv
// xunitF: SHA-256 compression unit. Each run consumes 16 schedule words and executes
// 16 rounds; the fourth run of a block folds the working variables into H.
module xunitf
   import sha256_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic              done,
   input  logic [DATA_W-1:0] in0,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic [DATA_W-1:0] out3,
   output logic [DATA_W-1:0] out4,
   output logic [DATA_W-1:0] out5,
   output logic [DATA_W-1:0] out6,
   output logic [DATA_W-1:0] out7,
   input  logic [7:0]        delay0,
   input  logic              init0
);

   state_t     state;
   logic [7:0] dcnt;
   logic [3:0] wcnt;
   logic [5:0] t;
   work_t      wv;
   work_t      wv_nxt;
   word_t      hst [0:7];
   word_t      k_t;

   // Round constant for the current round index.
   always_comb begin
      k_t = K[t];
   end

   sha256_round u_round (
      .cur (wv),
      .w   (in0),
      .k   (k_t),
      .nxt (wv_nxt)
   );

   assign out0 = hst[0];
   assign out1 = hst[1];
   assign out2 = hst[2];
   assign out3 = hst[3];
   assign out4 = hst[4];
   assign out5 = hst[5];
   assign out6 = hst[6];
   assign out7 = hst[7];

   // Run-control FSM together with the working-variable and hash-state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b1;
         dcnt  <= '0;
         wcnt  <= '0;
         t     <= '0;
         wv    <= '0;
         for (int i = 0; i < 8; i++) hst[i] <= IV[i];
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  done  <= 1'b0;
                  dcnt  <= delay0;
                  wcnt  <= '0;
                  state <= (delay0 != 8'd0) ? DELAY : STREAM;
                  if (init0) begin
                     for (int i = 0; i < 8; i++) hst[i] <= IV[i];
                     t  <= '0;
                     wv <= iv_work();
                  end else if (t == 6'd0) begin
                     // Start of a new block of an ongoing message.
                     wv <= {hst[0], hst[1], hst[2], hst[3],
                            hst[4], hst[5], hst[6], hst[7]};
                  end
               end
            end
            DELAY: begin
               // Leave on the edge that completes the programmed count.
               if (dcnt == 8'd1) state <= STREAM;
               else              dcnt  <= dcnt - 8'd1;
            end
            STREAM: begin
               wv   <= wv_nxt;
               t    <= t + 6'd1;
               wcnt <= wcnt + 4'd1;
               if (wcnt == LAST_WORD) state <= FINISH;
            end
            FINISH: begin
               // t back at 0 means round 63 just ran: the block is complete.
               if (t == 6'd0) begin
                  for (int i = 0; i < 8; i++) hst[i] <= hst[i] + work_get(wv, i);
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xunitf.sv
// Self-checking bench for xunitf: drives whole SHA-256 blocks as four 16-word runs
// and compares final digests (queued when a message is issued) against known hashes.
module tb_xunitf;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        done;
   logic [31:0] in0;
   logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
   logic [7:0]  delay0;
   logic        init0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   localparam logic [255:0] IV_D    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic [255:0] exp_q [$];
   logic [31:0]  blk  [0:15];
   logic [31:0]  wsch [0:63];

   xunitf #(.DATA_W(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .done   (done),
      .in0    (in0),
      .out0   (out0),
      .out1   (out1),
      .out2   (out2),
      .out3   (out3),
      .out4   (out4),
      .out5   (out5),
      .out6   (out6),
      .out7   (out7),
      .delay0 (delay0),
      .init0  (init0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] digest();
      return {out0, out1, out2, out3, out4, out5, out6, out7};
   endfunction

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Message schedule expansion of the current 16-word block.
   task automatic expand();
      for (int i = 0; i < 16; i++) wsch[i] = blk[i];
      for (int i = 16; i < 64; i++) begin
         wsch[i] = (rr(wsch[i-2], 17) ^ rr(wsch[i-2], 19) ^ (wsch[i-2] >> 10))
                 + wsch[i-7]
                 + (rr(wsch[i-15], 7) ^ rr(wsch[i-15], 18) ^ (wsch[i-15] >> 3))
                 + wsch[i-16];
      end
   endtask

   task automatic load_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   task automatic load_empty();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0] = 32'h80000000;
   endtask

   task automatic load_two1();
      blk[0]  = 32'h61626364; blk[1]  = 32'h62636465; blk[2]  = 32'h63646566; blk[3]  = 32'h64656667;
      blk[4]  = 32'h65666768; blk[5]  = 32'h66676869; blk[6]  = 32'h6768696a; blk[7]  = 32'h68696a6b;
      blk[8]  = 32'h696a6b6c; blk[9]  = 32'h6a6b6c6d; blk[10] = 32'h6b6c6d6e; blk[11] = 32'h6c6d6e6f;
      blk[12] = 32'h6d6e6f70; blk[13] = 32'h6e6f7071; blk[14] = 32'h80000000; blk[15] = 32'h00000000;
   endtask

   task automatic load_two2();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[15] = 32'h000001c0;
   endtask

   // One 16-word run. Called #1 after an edge with done=1. rst_at >= 0 aborts with a
   // reset (plus a simultaneous run pulse) at that word; fin_run pulses run in FINISH.
   task automatic do_run(input int ridx, input logic ini, input int dly,
                         input bit extra, input int rst_at, input bit fin_run);
      int e0;
      int n;
      run    = 1'b1;
      init0  = ini;
      delay0 = 8'(dly);
      in0    = $urandom;
      @(posedge clk); #1;
      e0    = cyc;
      run   = 1'b0;
      init0 = 1'b0;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL run_start_done run=%0d got=%b want=0", ridx, done);
      end
      for (int i = 0; i < dly; i++) begin
         in0 = $urandom;
         @(posedge clk); #1;
      end
      for (int j = 0; j < 16; j++) begin
         in0 = wsch[16*ridx + j];
         if (extra && (j == 3 || j == 10)) run = 1'b1;
         if (j == rst_at) begin
            rst = 1'b1;
            run = 1'b1;
         end
         @(posedge clk); #1;
         run = 1'b0;
         if (rst) begin
            rst = 1'b0;
            return;
         end
      end
      in0 = $urandom;
      if (fin_run) run = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(posedge clk); #1;
         run = 1'b0;
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL run_timeout run=%0d done=%b after %0d cycles", ridx, done, n);
      end else if (cyc - e0 != 17 + dly) begin
         errors++;
         $display("FAIL run_latency run=%0d got=%0d want=%0d", ridx, cyc - e0, 17 + dly);
      end
      if (fin_run) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b1) begin
            errors++;
            $display("FAIL finish_run_ignored run=%0d done=%b want=1", ridx, done);
         end
      end
   endtask

   // Four runs of one block; chk_h verifies H stays at IV until the block completes.
   task automatic run_block(input logic ini, input int dly, input bit chk_h,
                            input bit extra, input bit fin_run);
      expand();
      for (int r = 0; r < 4; r++) begin
         do_run(r, ini && (r == 0), dly, extra, -1, fin_run);
         if (chk_h && r < 3) begin
            checks++;
            if (digest() !== IV_D) begin
               errors++;
               $display("FAIL h_hold run=%0d got=%h want=%h", r, digest(), IV_D);
            end
         end
      end
   endtask

   task automatic check_digest(input string name);
      logic [255:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty, got=%h", name, digest());
      end else begin
         exp = exp_q.pop_front();
         if (digest() !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, digest(), exp);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b1; init0 = 1'b1; delay0 = 8'd0; in0 = 32'hdeadbeef;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL reset_done got=%b want=1", done); end
      checks++;
      if (digest() !== IV_D) begin errors++; $display("FAIL reset_iv got=%h want=%h", digest(), IV_D); end
      rst = 1'b0; run = 1'b0; init0 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL reset_run_ignored done=%b want=1", done); end
   endtask

   task automatic test_abc();
      exp_q.push_back(ABC_D);
      load_abc();
      run_block(1'b1, 0, 1'b1, 1'b0, 1'b0);
      check_digest("abc");
   endtask

   task automatic test_empty();
      exp_q.push_back(EMPTY_D);
      load_empty();
      run_block(1'b1, 0, 1'b1, 1'b0, 1'b0);
      check_digest("empty");
   endtask

   task automatic test_two_block();
      exp_q.push_back(TWO_D);
      load_two1();
      run_block(1'b1, 0, 1'b1, 1'b0, 1'b0);
      load_two2();
      run_block(1'b0, 0, 1'b0, 1'b0, 1'b0);
      check_digest("two_block");
   endtask

   task automatic test_delay();
      exp_q.push_back(ABC_D);
      load_abc();
      run_block(1'b1, 3, 1'b1, 1'b0, 1'b0);
      check_digest("abc_delay3");
   endtask

   task automatic test_long_delay();
      load_abc();
      expand();
      do_run(0, 1'b1, 255, 1'b0, -1, 1'b0);
      checks++;
      if (digest() !== IV_D) begin
         errors++;
         $display("FAIL long_delay_h got=%h want=%h", digest(), IV_D);
      end
   endtask

   task automatic test_extra_run();
      exp_q.push_back(ABC_D);
      load_abc();
      run_block(1'b1, 0, 1'b1, 1'b1, 1'b0);
      check_digest("abc_extra_run");
   endtask

   task automatic test_rst_midrun();
      load_abc();
      expand();
      do_run(0, 1'b1, 0, 1'b0, -1, 1'b0);
      do_run(1, 1'b0, 0, 1'b0, 8, 1'b0);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL rst_mid_done got=%b want=1", done); end
      checks++;
      if (digest() !== IV_D) begin errors++; $display("FAIL rst_mid_iv got=%h want=%h", digest(), IV_D); end
      @(posedge clk); #1;
      exp_q.push_back(ABC_D);
      run_block(1'b1, 0, 1'b1, 1'b0, 1'b0);
      check_digest("abc_after_rst");
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(EMPTY_D);
      load_empty();
      run_block(1'b1, 0, 1'b1, 1'b0, 1'b1);
      check_digest("empty_back_to_back");
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; init0 = 1'b0; delay0 = 8'd0; in0 = 32'h0;
      test_reset();
      test_abc();
      test_empty();
      test_two_block();
      test_delay();
      test_long_delay();
      test_extra_run();
      test_rst_midrun();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
